equiv_sweep_ctrl: RTL and testbench
===================================

EQUIV_SWEEP_CTRL -- requirements
Module: equiv_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 2: number of combined test-input bits driven to both designs under test; legal range 1..16.
REQ-002 The block SHALL have parameter SETTLE, default 1: number of wait cycles after each vector is applied and before outputs are compared; legal range 1..255.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-004 clk  in  1  Sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  Synchronous active-high reset.
REQ-006 start  in  1  Single-cycle request to begin an exhaustive sweep.
REQ-007 vec  out  N  Test vector driven in parallel to both DUT inputs; MSB maps to A, LSB to B when N=2.
REQ-008 x_in  in  1  Output of first implementation (combinational, driven from vec).
REQ-009 y_in  in  1  Output of second implementation (combinational, driven from vec).
REQ-010 busy  out  1  High while a sweep is in progress.
REQ-011 done  out  1  High while in DONE state.
REQ-012 pass  out  1  Valid only when done=1; 1 means zero mismatches.
REQ-013 mismatch_cnt  out  N+1  Number of vectors where x_in != y_in.
REQ-014 fail_valid  out  1  High once a mismatch has been recorded in the current sweep.
REQ-015 fail_vec  out  N  Value of vec at the first recorded mismatch.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, COMPARE, DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, start=1 SHALL, on that edge: set vec=0; clear mismatch_cnt, fail_valid and fail_vec; load the settle counter with SETTLE; and enter WAIT.
REQ-018 WAIT SHALL hold vec stable and remain for exactly SETTLE cycles, then enter COMPARE.
REQ-019 COMPARE SHALL last one cycle and SHALL sample x_in and y_in; if they differ, mismatch_cnt SHALL increment by 1, and if fail_valid=0, fail_vec SHALL take vec and fail_valid SHALL go to 1.
REQ-020 From COMPARE, if vec = 2^N-1 the FSM SHALL enter DONE; otherwise vec SHALL increment by 1 and the FSM SHALL enter WAIT with the settle counter reloaded.
REQ-021 Each vector SHALL occupy exactly SETTLE+1 cycles; done SHALL rise 2^N*(SETTLE+1) cycles after the edge on which start was accepted.
REQ-022 busy SHALL be 1 exactly in WAIT and COMPARE; done SHALL be 1 exactly in DONE.
REQ-023 pass SHALL equal (mismatch_cnt == 0) while done=1 and SHALL be 0 otherwise.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 mismatch_cnt SHALL NOT wrap; its width N+1 holds the maximum value 2^N.
REQ-026 vec SHALL never wrap from 2^N-1 to 0 within a sweep.
REQ-027 DONE SHALL hold all results until reset or a new accepted start.

Reset
REQ-028 rst=1 SHALL, on the clock edge, force state IDLE, vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0 and fail_vec=0.
REQ-029 rst SHALL take priority over start and over any sweep in progress; an aborted sweep SHALL leave no residual results.

Configuration
REQ-030 Macro STOP_ON_FAIL_EN SHALL control early stop on the first mismatch.
REQ-031 When STOP_ON_FAIL_EN is defined, the first mismatch in COMPARE SHALL send the FSM directly to DONE with vec held at the failing value and mismatch_cnt=1.
REQ-032 When STOP_ON_FAIL_EN is undefined, the sweep SHALL always cover all 2^N vectors.

Verification
REQ-033 N=2, SETTLE=1, y_in tied to x_in, start pulse -> vec steps 0,1,2,3 every 2 cycles; done=1 8 cycles after start; pass=1; mismatch_cnt=0; fail_valid=0.
REQ-034 N=2, SETTLE=1, y_in differs only at vec=2 (macro undefined) -> done after 8 cycles; mismatch_cnt=1; fail_vec=2; pass=0.
REQ-035 Same as REQ-034 with STOP_ON_FAIL_EN defined -> DONE entered at the COMPARE of vec=2 (6 cycles after start); vec=2; mismatch_cnt=1.
REQ-036 y_in = ~x_in for all vectors, N=2 -> mismatch_cnt=4; fail_vec=0; pass=0.
REQ-037 Assert rst mid-sweep at vec=1 -> next edge: IDLE, all outputs 0; start pulses during busy are ignored (sweep length unchanged).
REQ-038 Start pulse in DONE -> results cleared and new sweep begins from vec=0; N=3, SETTLE=3 gives done 32 cycles after start.

Source files
------------

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep controller: steps vec over 0..2^N-1, compares x_in/y_in after SETTLE cycles.
// Optional macro STOP_ON_FAIL_EN ends the sweep at the first recorded mismatch.
module equiv_sweep_ctrl #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] vec,
    input  logic         x_in,
    input  logic         y_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mismatch_cnt,
    output logic         fail_valid,
    output logic [N-1:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [N-1:0] VEC_LAST  = {N{1'b1}};
    localparam logic [N-1:0] VEC_ZERO  = {N{1'b0}};
    localparam logic [N-1:0] VEC_ONE   = N'(1);
    localparam logic [N:0]   CNT_ZERO  = {(N+1){1'b0}};
    localparam logic [N:0]   CNT_ONE   = (N+1)'(1);
    localparam logic [7:0]   SETTLE_LD = 8'(SETTLE);

    state_t       state_r, state_s;
    logic [7:0]   settle_r, settle_s;
    logic [N-1:0] vec_s, fail_vec_s;
    logic [N:0]   mismatch_cnt_s;
    logic         fail_valid_s;
    logic         miss_s;
    logic         stop_s;

    // Next-state and next-result computation for the sweep FSM.
    always_comb begin
        state_s        = state_r;
        settle_s       = settle_r;
        vec_s          = vec;
        mismatch_cnt_s = mismatch_cnt;
        fail_valid_s   = fail_valid;
        fail_vec_s     = fail_vec;
        miss_s         = (x_in != y_in);
        stop_s         = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_s          = VEC_ZERO;
                    mismatch_cnt_s = CNT_ZERO;
                    fail_valid_s   = 1'b0;
                    fail_vec_s     = VEC_ZERO;
                    settle_s       = SETTLE_LD;
                    state_s        = S_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            S_WAIT: begin
                if (settle_r <= 8'd1) begin
                    state_s = S_COMPARE;
                end else begin
                    settle_s = settle_r - 8'd1;
                end
            end
            S_COMPARE: begin
                if (miss_s) begin
                    mismatch_cnt_s = mismatch_cnt + CNT_ONE;
                    if (!fail_valid) begin
                        fail_valid_s = 1'b1;
                        fail_vec_s   = vec;
                    end else begin
                        fail_valid_s = fail_valid;
                    end
`ifdef STOP_ON_FAIL_EN
                    stop_s = 1'b1;
`else
                    stop_s = 1'b0;
`endif
                end else begin
                    stop_s = 1'b0;
                end
                // The last vector never wraps back to zero; it ends the sweep instead.
                if (stop_s || (vec == VEC_LAST)) begin
                    state_s = S_DONE;
                end else begin
                    vec_s    = vec + VEC_ONE;
                    settle_s = SETTLE_LD;
                    state_s  = S_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, results and status flags, all registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            settle_r     <= 8'd0;
            vec          <= VEC_ZERO;
            mismatch_cnt <= CNT_ZERO;
            fail_valid   <= 1'b0;
            fail_vec     <= VEC_ZERO;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_r     <= settle_s;
            vec          <= vec_s;
            mismatch_cnt <= mismatch_cnt_s;
            fail_valid   <= fail_valid_s;
            fail_vec     <= fail_vec_s;
            busy         <= (state_s == S_WAIT) || (state_s == S_COMPARE);
            done         <= (state_s == S_DONE);
            pass         <= (state_s == S_DONE) && (mismatch_cnt_s == CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Self-checking bench for equiv_sweep_ctrl: N=2/SETTLE=1 and N=3/SETTLE=3 instances, table-driven with a scoreboard.
module tb_equiv_sweep_ctrl;

    typedef struct {
        int mask;
        int cnt;
        int fvalid;
        int fvec;
        int pass;
        int lat;
        int vend;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst2 = 1'b1, start2 = 1'b0;
    logic       rst3 = 1'b1, start3 = 1'b0;
    logic [3:0] mask2 = 4'd0;
    logic [7:0] mask3 = 8'd0;

    logic [1:0] vec2, fail_vec2;
    logic [2:0] mismatch_cnt2;
    logic       busy2, done2, pass2, fail_valid2, x2, y2;
    logic [2:0] vec3, fail_vec3;
    logic [3:0] mismatch_cnt3;
    logic       busy3, done3, pass3, fail_valid3, x3, y3;

    int   total = 0;
    int   passed = 0;
    exp_t sb[$];
    exp_t tbl[5];

    assign x2 = ^vec2;
    assign y2 = x2 ^ mask2[vec2];
    assign x3 = ^vec3;
    assign y3 = x3 ^ mask3[vec3];

    always #5 clk = ~clk;

    equiv_sweep_ctrl #(.N(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst2), .start(start2), .vec(vec2), .x_in(x2), .y_in(y2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(mismatch_cnt2),
        .fail_valid(fail_valid2), .fail_vec(fail_vec2)
    );

    equiv_sweep_ctrl #(.N(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .vec(vec3), .x_in(x3), .y_in(y3),
        .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(mismatch_cnt3),
        .fail_valid(fail_valid3), .fail_vec(fail_vec3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int o_vec(input int w);
        return (w == 3) ? int'(vec3) : int'(vec2);
    endfunction
    function automatic int o_busy(input int w);
        return (w == 3) ? int'(busy3) : int'(busy2);
    endfunction
    function automatic int o_done(input int w);
        return (w == 3) ? int'(done3) : int'(done2);
    endfunction
    function automatic int o_cnt(input int w);
        return (w == 3) ? int'(mismatch_cnt3) : int'(mismatch_cnt2);
    endfunction
    function automatic int o_fvalid(input int w);
        return (w == 3) ? int'(fail_valid3) : int'(fail_valid2);
    endfunction
    function automatic int o_fvec(input int w);
        return (w == 3) ? int'(fail_vec3) : int'(fail_vec2);
    endfunction
    function automatic int o_pass(input int w);
        return (w == 3) ? int'(pass3) : int'(pass2);
    endfunction

    // Start one sweep on the chosen instance, expect cleared results, then score the DONE results.
    task automatic sweep(input int w, input exp_t e);
        exp_t got;
        int   cyc;
        @(negedge clk);
        if (w == 3) begin mask3 = e.mask[7:0]; start3 = 1'b1; end
        else begin mask2 = e.mask[3:0]; start2 = 1'b1; end
        sb.push_back(e);
        tick();
        start2 = 1'b0;
        start3 = 1'b0;
        chk("busy_after_start", o_busy(w), 1);
        chk("done_after_start", o_done(w), 0);
        chk("vec_after_start", o_vec(w), 0);
        chk("cnt_cleared", o_cnt(w), 0);
        chk("fvalid_cleared", o_fvalid(w), 0);
        cyc = 0;
        while (o_done(w) == 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        got = sb.pop_front();
        if (o_done(w) == 0) chk("done_timeout", 0, 1);
        chk("latency", cyc, got.lat);
        chk("mismatch_cnt", o_cnt(w), got.cnt);
        chk("fail_valid", o_fvalid(w), got.fvalid);
        chk("fail_vec", o_fvec(w), got.fvec);
        chk("pass", o_pass(w), got.pass);
        chk("vec_at_done", o_vec(w), got.vend);
        chk("busy_at_done", o_busy(w), 0);
        tick();
        chk("done_hold", o_done(w), 1);
        chk("cnt_hold", o_cnt(w), got.cnt);
    endtask

    initial begin
        int   cyc;
        exp_t e3;
`ifdef STOP_ON_FAIL_EN
        tbl[0] = '{mask: 4'b0000, cnt: 0, fvalid: 0, fvec: 0, pass: 1, lat: 8, vend: 3};
        tbl[1] = '{mask: 4'b0100, cnt: 1, fvalid: 1, fvec: 2, pass: 0, lat: 6, vend: 2};
        tbl[2] = '{mask: 4'b1111, cnt: 1, fvalid: 1, fvec: 0, pass: 0, lat: 2, vend: 0};
        tbl[3] = '{mask: 4'b1001, cnt: 1, fvalid: 1, fvec: 0, pass: 0, lat: 2, vend: 0};
        tbl[4] = '{mask: 4'b1000, cnt: 1, fvalid: 1, fvec: 3, pass: 0, lat: 8, vend: 3};
`else
        tbl[0] = '{mask: 4'b0000, cnt: 0, fvalid: 0, fvec: 0, pass: 1, lat: 8, vend: 3};
        tbl[1] = '{mask: 4'b0100, cnt: 1, fvalid: 1, fvec: 2, pass: 0, lat: 8, vend: 3};
        tbl[2] = '{mask: 4'b1111, cnt: 4, fvalid: 1, fvec: 0, pass: 0, lat: 8, vend: 3};
        tbl[3] = '{mask: 4'b1001, cnt: 2, fvalid: 1, fvec: 0, pass: 0, lat: 8, vend: 3};
        tbl[4] = '{mask: 4'b1000, cnt: 1, fvalid: 1, fvec: 3, pass: 0, lat: 8, vend: 3};
`endif

        tick();
        tick();
        chk("rst_vec", int'(vec2), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_pass", int'(pass2), 0);
        chk("rst_cnt", int'(mismatch_cnt2), 0);
        chk("rst_fvalid", int'(fail_valid2), 0);
        chk("rst_fvec", int'(fail_vec2), 0);
        chk("rst3_done", int'(done3), 0);
        @(negedge clk);
        rst2 = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 5; i++) sweep(2, tbl[i]);

        // Start pulses while busy are ignored: vec keeps stepping every two cycles, done still at 8.
        @(negedge clk);
        mask2 = 4'b0000;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("seq_vec_k0", int'(vec2), 0);
        for (int k = 1; k < 8; k++) begin
            start2 = (k == 3 || k == 6);
            tick();
            start2 = 1'b0;
            chk("seq_vec_step", int'(vec2), k / 2);
            chk("seq_busy", int'(busy2), 1);
        end
        tick();
        chk("seq_done_at_8", int'(done2), 1);
        chk("seq_pass", int'(pass2), 1);

        // Reset mid-sweep once vec reaches 1: everything returns to zero on the next edge.
        @(negedge clk);
`ifdef STOP_ON_FAIL_EN
        mask2 = 4'b0000;
`else
        mask2 = 4'b0001;
`endif
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (vec2 != 2'd1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reach_vec1", int'(vec2), 1);
        @(negedge clk);
        rst2 = 1'b1;
        tick();
        chk("abort_vec", int'(vec2), 0);
        chk("abort_busy", int'(busy2), 0);
        chk("abort_done", int'(done2), 0);
        chk("abort_cnt", int'(mismatch_cnt2), 0);
        chk("abort_fvalid", int'(fail_valid2), 0);
        chk("abort_fvec", int'(fail_vec2), 0);
        @(negedge clk);
        rst2 = 1'b0;
        tick();
        chk("idle_after_abort", int'(busy2) + int'(done2), 0);

        // N=3, SETTLE=3: mismatch at vec 5, then restart from DONE with a clean compare.
`ifdef STOP_ON_FAIL_EN
        e3 = '{mask: 8'b0010_0000, cnt: 1, fvalid: 1, fvec: 5, pass: 0, lat: 24, vend: 5};
`else
        e3 = '{mask: 8'b0010_0000, cnt: 1, fvalid: 1, fvec: 5, pass: 0, lat: 32, vend: 7};
`endif
        sweep(3, e3);
        e3 = '{mask: 8'b0000_0000, cnt: 0, fvalid: 0, fvec: 0, pass: 1, lat: 32, vend: 7};
        sweep(3, e3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
